// File: rtl/sfx_pkg.sv
// Shared types and defaults for the sound-effect scheduler.
// Holds the FSM state encoding and the default tone field widths/amplitude.
// No ports; imported by the scheduler top and its sub-modules.
package sfx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          HP_W_DEF      = 16;
  localparam int          LEN_W_DEF     = 20;
  localparam int          SAMPLE_W_DEF  = 32;
  localparam logic [31:0] AMPLITUDE_DEF = 32'h0800_0000;

endpackage

// File: rtl/sfx_scheduler_if.sv
// Audio-out bus between the scheduler and the audio controller output FIFO.
// Ports: audio_out_allowed (FIFO has space), write_audio_out (one-cycle write
// strobe), left/right_channel_audio_out (sample data, both carry the same value).
interface sfx_scheduler_if #(
  parameter int SAMPLE_W = 32
);

  logic                audio_out_allowed;
  logic                write_audio_out;
  logic [SAMPLE_W-1:0] left_channel_audio_out;
  logic [SAMPLE_W-1:0] right_channel_audio_out;

  // Scheduler side
  modport master (
    input  audio_out_allowed,
    output write_audio_out,
    output left_channel_audio_out,
    output right_channel_audio_out
  );

  // Audio controller side
  modport slave (
    output audio_out_allowed,
    input  write_audio_out,
    input  left_channel_audio_out,
    input  right_channel_audio_out
  );

endinterface

// File: rtl/sfx_priority_pick.sv
// Combinational find-first-set: lowest set bit of vec wins (index 0 = top priority).
// Ports: vec (request bits in), idx (index of lowest set bit, 0 when none), vld (any bit set).
// Zero latency, purely combinational.
module sfx_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 vld
);

  localparam int IW = $clog2(N);

  // Scan from the top so the lowest set index is the last assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign vld = |vec;

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: latches per-requester triggers, grants by fixed priority
// and plays that requester's square-wave tone into the audio-out FIFO, one sample
// per write/allowed handshake (at most one write every 2 cycles), then pulses done.
// Ports: CLOCK_50, resetn (sync, active-low), req/req_half_period/req_len (per-requester
// trigger and tone fields), aud (audio-out bus, master side), busy, grant_id, done.
// Optional macro SFX_PREEMPT_EN: a lower pending index aborts the current tone in GAP.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int                  NUM_REQ   = 4,
  parameter int                  SAMPLE_W  = SAMPLE_W_DEF,
  parameter logic [SAMPLE_W-1:0] AMPLITUDE = AMPLITUDE_DEF,
  parameter int                  HP_W      = HP_W_DEF,
  parameter int                  LEN_W     = LEN_W_DEF
) (
  input  logic                       CLOCK_50,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*HP_W-1:0]    req_half_period,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  sfx_scheduler_if.master            aud,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [NUM_REQ-1:0]         done
);

  localparam int                  GW  = $clog2(NUM_REQ);
  localparam logic [SAMPLE_W-1:0] POS = AMPLITUDE;
  localparam logic [SAMPLE_W-1:0] NEG = (~AMPLITUDE) + SAMPLE_W'(1);

  state_t               state, state_nxt;
  logic [NUM_REQ-1:0]   pending;
  logic [NUM_REQ-1:0]   clr;
  logic [HP_W-1:0]      hp_cnt, hp_reload;
  logic [LEN_W-1:0]     len_cnt;
  logic                 phase;
  logic [GW-1:0]        gid;
  logic [SAMPLE_W-1:0]  last_smp;
  logic [SAMPLE_W-1:0]  cur_smp;

  logic [GW-1:0]        pick_idx;
  logic                 pick_vld;
  logic [HP_W-1:0]      pick_hp;
  logic [HP_W-1:0]      pick_hp_eff;
  logic [LEN_W-1:0]     pick_len;
  logic                 preempt;
  logic                 load;
  logic                 wr;

  // One picker serves both the IDLE grant and the GAP preemption check.
  sfx_priority_pick #(.N(NUM_REQ)) u_pick (
    .vec (pending),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  assign pick_hp     = req_half_period[pick_idx*HP_W +: HP_W];
  assign pick_len    = req_len[pick_idx*LEN_W +: LEN_W];
  // A zero half-period would never reach the toggle point; treat it as 1.
  assign pick_hp_eff = (pick_hp == '0) ? HP_W'(1) : pick_hp;

`ifdef SFX_PREEMPT_EN
  assign preempt = (state == GAP) && pick_vld && (pick_idx < gid);
`else
  assign preempt = 1'b0;
`endif

  assign load    = ((state == IDLE) && pick_vld) || preempt;
  assign wr      = (state == PLAY) && aud.audio_out_allowed;
  assign cur_smp = phase ? NEG : POS;

  always_comb begin
    clr = '0;
    if (load) clr[pick_idx] = 1'b1;
  end

  // FSM: state register
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pick_vld) state_nxt = (pick_len == '0) ? DONE : PLAY;
      PLAY: if (wr)       state_nxt = (len_cnt == LEN_W'(1)) ? DONE : GAP;
      GAP: begin
        if (preempt) state_nxt = (pick_len == '0) ? DONE : PLAY;
        else         state_nxt = PLAY;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy                        = (state != IDLE);
    aud.write_audio_out         = wr;
    done                        = '0;
    if (state == DONE) done[gid] = 1'b1;
    // Data shows the live sample on a write, otherwise holds the last one written.
    if (state == IDLE)  aud.left_channel_audio_out = '0;
    else if (wr)        aud.left_channel_audio_out = cur_smp;
    else                aud.left_channel_audio_out = last_smp;
    aud.right_channel_audio_out = aud.left_channel_audio_out;
  end

  assign grant_id = gid;

  // Pending bits, tone counters and grant latch
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      pending   <= '0;
      gid       <= '0;
      hp_cnt    <= '0;
      hp_reload <= '0;
      len_cnt   <= '0;
      phase     <= 1'b0;
      last_smp  <= '0;
    end else begin
      // New triggers win over the grant clear, so a replay is never lost.
      pending <= (pending & ~clr) | req;

      if (load) begin
        gid       <= pick_idx;
        hp_cnt    <= pick_hp_eff;
        hp_reload <= pick_hp_eff;
        len_cnt   <= pick_len;
        phase     <= 1'b0;
      end else if (wr) begin
        len_cnt <= len_cnt - LEN_W'(1);
        if (hp_cnt == HP_W'(1)) begin
          phase  <= ~phase;
          hp_cnt <= hp_reload;
        end else begin
          hp_cnt <= hp_cnt - HP_W'(1);
        end
      end

      if (state == IDLE) last_smp <= '0;
      else if (wr)       last_smp <= cur_smp;
    end
  end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler: single tone, priority order, backpressure,
// zero length / zero half-period, reset mid-tone and preemption (both builds).
// Writes and done pulses are logged at the falling edge and checked against hand values.
module tb_sfx_scheduler;

  localparam logic [31:0] POS = 32'h0800_0000;
  localparam logic [31:0] NEG = 32'hF800_0000;
  localparam logic [63:0] XV  = {64{1'bx}};

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req    = '0;
  logic [63:0] hp_v   = '0;
  logic [79:0] len_v  = '0;
  logic        busy;
  logic [1:0]  grant_id;
  logic [3:0]  done;

  sfx_scheduler_if #(.SAMPLE_W(32)) aud ();

  sfx_scheduler dut (
    .CLOCK_50        (clk),
    .resetn          (resetn),
    .req             (req),
    .req_half_period (hp_v),
    .req_len         (len_v),
    .aud             (aud),
    .busy            (busy),
    .grant_id        (grant_id),
    .done            (done)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wcyc[$];
  logic [31:0] wsmp[$];
  logic [1:0]  wgid[$];
  logic [3:0]  dval[$];
  int          dcyc[$];
  int          lr_bad = 0;

  always @(negedge clk) begin
    if (aud.write_audio_out) begin
      wcyc.push_back(cyc);
      wsmp.push_back(aud.left_channel_audio_out);
      wgid.push_back(grant_id);
      if (aud.right_channel_audio_out !== aud.left_channel_audio_out) lr_bad++;
    end
    if (done != 4'b0) begin
      dval.push_back(done);
      dcyc.push_back(cyc);
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ws(input int i);
    return (i < wsmp.size()) ? 64'(wsmp[i]) : XV;
  endfunction
  function automatic logic [63:0] wc(input int i);
    return (i < wcyc.size()) ? 64'(wcyc[i]) : XV;
  endfunction
  function automatic logic [63:0] wg(input int i);
    return (i < wgid.size()) ? 64'(wgid[i]) : XV;
  endfunction
  function automatic logic [63:0] dv(input int i);
    return (i < dval.size()) ? 64'(dval[i]) : XV;
  endfunction
  function automatic logic [63:0] dc(input int i);
    return (i < dcyc.size()) ? 64'(dcyc[i]) : XV;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    wcyc.delete(); wsmp.delete(); wgid.delete(); dval.delete(); dcyc.delete();
  endtask

  task automatic set_tone(input int idx, input logic [15:0] hp, input logic [19:0] len);
    hp_v[idx*16 +: 16]  = hp;
    len_v[idx*20 +: 20] = len;
  endtask

  task automatic fire(input logic [3:0] m, output int k);
    req = m;
    k   = cyc;
    tick(1);
    req = '0;
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int b = 0;
    while (wsmp.size() < n && b < budget) begin
      tick(1);
      b++;
    end
    chk(tag, 64'(wsmp.size() >= n), 64'd1);
  endtask

  logic [31:0] e_hp2[6] = '{POS, POS, NEG, NEG, POS, POS};
  logic [31:0] e_alt[6] = '{POS, NEG, POS, POS, NEG, POS};
  logic [31:0] e_hp0[4] = '{POS, NEG, POS, NEG};

  initial begin
    int k;
    int n0;

    // Reset state
    aud.audio_out_allowed = 1'b1;
    resetn = 1'b0;
    tick(2);
    chk("rst_write", 64'(aud.write_audio_out), 64'd0);
    chk("rst_left",  64'(aud.left_channel_audio_out), 64'd0);
    chk("rst_right", 64'(aud.right_channel_audio_out), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_gid",   64'(grant_id), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    resetn = 1'b1;
    tick(2);

    // Single tone: requester 2, half-period 2, length 6
    clear_logs();
    set_tone(2, 16'd2, 20'd6);
    fire(4'b0100, k);
    tick(20);
    chk("t1_nwr", 64'(wsmp.size()), 64'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("t1_smp%0d", i), ws(i), 64'(e_hp2[i]));
    chk("t1_first_cyc", wc(0), 64'(k + 2));
    chk("t1_last_cyc",  wc(5), 64'(k + 12));
    chk("t1_gid",       wg(0), 64'd2);
    chk("t1_ndone",     64'(dval.size()), 64'd1);
    chk("t1_done",      dv(0), 64'b0100);
    chk("t1_done_cyc",  dc(0), 64'(k + 13));

    // Simultaneous triggers 1 and 3, length 3 each
    clear_logs();
    set_tone(1, 16'd1, 20'd3);
    set_tone(3, 16'd1, 20'd3);
    fire(4'b1010, k);
    tick(25);
    chk("t2_nwr", 64'(wsmp.size()), 64'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("t2_smp%0d", i), ws(i), 64'(e_alt[i]));
    chk("t2_gid_a",    wg(2), 64'd1);
    chk("t2_gid_b",    wg(3), 64'd3);
    chk("t2_ndone",    64'(dval.size()), 64'd2);
    chk("t2_done_a",   dv(0), 64'b0010);
    chk("t2_done_b",   dv(1), 64'b1000);
    chk("t2_dcyc_a",   dc(0), 64'(k + 7));
    chk("t2_dcyc_b",   dc(1), 64'(k + 14));

    // Backpressure: allowed low for 10 cycles after two writes
    clear_logs();
    set_tone(0, 16'd2, 20'd6);
    fire(4'b0001, k);
    wait_writes("t3_wait", 2, 20);
    aud.audio_out_allowed = 1'b0;
    n0 = wsmp.size();
    tick(10);
    chk("t3_stall", 64'(wsmp.size()), 64'(n0));
    aud.audio_out_allowed = 1'b1;
    tick(20);
    chk("t3_nwr", 64'(wsmp.size()), 64'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_smp%0d", i), ws(i), 64'(e_hp2[i]));
    chk("t3_resume_gap", wc(2) - wc(1), 64'd11);
    chk("t3_done", dv(0), 64'b0001);

    // Zero length: done with no writes
    clear_logs();
    set_tone(2, 16'd5, 20'd0);
    fire(4'b0100, k);
    tick(6);
    chk("t4_nwr",      64'(wsmp.size()), 64'd0);
    chk("t4_ndone",    64'(dval.size()), 64'd1);
    chk("t4_done",     dv(0), 64'b0100);
    chk("t4_done_cyc", dc(0), 64'(k + 2));

    // Zero half-period behaves as 1
    clear_logs();
    set_tone(2, 16'd0, 20'd4);
    fire(4'b0100, k);
    tick(15);
    chk("t5_nwr", 64'(wsmp.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t5_smp%0d", i), ws(i), 64'(e_hp0[i]));

    // Reset mid-tone
    clear_logs();
    set_tone(1, 16'd1, 20'd20);
    fire(4'b0010, k);
    wait_writes("t6_wait", 3, 30);
    aud.audio_out_allowed = 1'b0;
    resetn = 1'b0;
    tick(1);
    chk("t6_write", 64'(aud.write_audio_out), 64'd0);
    chk("t6_left",  64'(aud.left_channel_audio_out), 64'd0);
    chk("t6_right", 64'(aud.right_channel_audio_out), 64'd0);
    chk("t6_busy",  64'(busy), 64'd0);
    chk("t6_gid",   64'(grant_id), 64'd0);
    chk("t6_done",  64'(done), 64'd0);
    resetn = 1'b1;
    aud.audio_out_allowed = 1'b1;
    clear_logs();
    tick(10);
    chk("t6_nwr_after",   64'(wsmp.size()), 64'd0);
    chk("t6_ndone_after", 64'(dval.size()), 64'd0);
    chk("t6_busy_after",  64'(busy), 64'd0);
    set_tone(2, 16'd1, 20'd2);
    fire(4'b0100, k);
    tick(10);
    chk("t6_re_nwr",   64'(wsmp.size()), 64'd2);
    chk("t6_re_smp0",  ws(0), 64'(POS));
    chk("t6_re_smp1",  ws(1), 64'(NEG));
    chk("t6_re_first", wc(0), 64'(k + 2));
    chk("t6_re_done",  dv(0), 64'b0100);

    // Preemption: long tone on 3, then a trigger on 0 after 5 writes
    clear_logs();
    set_tone(3, 16'd1, 20'd100);
    set_tone(0, 16'd1, 20'd2);
    fire(4'b1000, k);
    wait_writes("t7_wait", 5, 30);
    fire(4'b0001, k);
    tick(260);
`ifdef SFX_PREEMPT_EN
    chk("t7_nwr",      64'(wsmp.size()), 64'd8);
    chk("t7_gid_last3", wg(5), 64'd3);
    chk("t7_gid_first0", wg(6), 64'd0);
    chk("t7_smp_new",  ws(6), 64'(POS));
    chk("t7_ndone",    64'(dval.size()), 64'd1);
    chk("t7_done",     dv(0), 64'b0001);
`else
    chk("t7_nwr",      64'(wsmp.size()), 64'd102);
    chk("t7_gid_last3", wg(99), 64'd3);
    chk("t7_gid_first0", wg(100), 64'd0);
    chk("t7_smp_new",  ws(100), 64'(POS));
    chk("t7_ndone",    64'(dval.size()), 64'd2);
    chk("t7_done_a",   dv(0), 64'b1000);
    chk("t7_done_b",   dv(1), 64'b0001);
`endif

    chk("lr_equal", 64'(lr_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sfx_scheduler.md
# sfx_scheduler

Sound-effect scheduler that shares the single audio-out path of the audio controller between NUM_REQ game requesters (hit, miss, game-over, etc.). Each requester pulses a trigger. The block latches the trigger, picks one requester by fixed priority, and synthesizes that requester's square-wave tone. It writes each sample into the audio controller's output FIFO using the controller's write/allowed handshake, then reports completion per requester.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; index 0 has the highest priority.
- SAMPLE_W, 32, width of the audio sample and of each channel.
- AMPLITUDE, 32'h0800_0000, magnitude of the square wave; samples are +AMPLITUDE or -AMPLITUDE in two's complement.
- HP_W, 16, width of the half-period field.
- LEN_W, 20, width of the length field.

Ports:
- CLOCK_50  in  1  only clock.
- resetn  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  one-cycle trigger per requester.
- req_half_period  in  NUM_REQ*HP_W  per-requester half-period in samples; slice i belongs to requester i.
- req_len  in  NUM_REQ*LEN_W  per-requester tone length in samples.
- audio_out_allowed  in  1  from the audio controller; the FIFO has space.
- write_audio_out  out  1  one-cycle write strobe to the audio controller.
- left_channel_audio_out  out  SAMPLE_W  sample for the left channel.
- right_channel_audio_out  out  SAMPLE_W  same value as the left channel.
- busy  out  1  high while a tone is active.
- grant_id  out  $clog2(NUM_REQ)  index of the requester being served.
- done  out  NUM_REQ  one-cycle pulse when requester i's tone completes.

## Operation
- Pending register: pending[i] is set on req[i] and cleared when requester i is granted.
  - Set and clear in the same cycle: set wins.
  - A repeated req while pending[i] is already set merges into the one pending bit.
  - A req from the requester currently playing queues a replay after the current tone.
- FSM states are IDLE, PLAY, GAP and DONE.
- IDLE:
  - If pending is zero, stay in IDLE.
  - Otherwise take g = the lowest set index (find-first-set).
  - Load hp_cnt = max(req_half_period[g], 1), len_cnt = req_len[g] and phase = 0 (positive half).
  - Latch grant_id = g and go to PLAY.
  - If req_len[g] == 0, go to DONE directly; no writes are issued.
- PLAY:
  - Wait for audio_out_allowed.
  - When audio_out_allowed is high, assert write_audio_out for that cycle. Both channels carry phase ? -AMPLITUDE : +AMPLITUDE.
  - In the same cycle, decrement len_cnt and decrement hp_cnt.
  - When hp_cnt reaches 0, toggle phase and reload hp_cnt from the latched half-period.
  - If len_cnt was 1, go to DONE; otherwise go to GAP.
- GAP: one idle cycle so the controller's allowed flag can update after a write. Return to PLAY.
- DONE: pulse done[grant_id] for one cycle and go to IDLE.
- The tone parameters are latched at grant; later changes to req_half_period or req_len do not affect the tone in progress.
- Sample data outputs hold their last value when no write is in progress. They return to 0 in IDLE.

## Timing
- Reset (synchronous, resetn low at a rising edge):
  - write_audio_out = 0, both channel outputs = 0, busy = 0, grant_id = 0, done = 0.
  - pending = 0, FSM = IDLE.
- Reset during PLAY or GAP aborts the tone with no done pulse.
- Latency:
  - req[i] high in cycle k gives pending[i] = 1 after edge k.
  - Grant and PLAY entry take effect after edge k+1.
  - The first write strobe can occur in cycle k+2 if audio_out_allowed is high.
- Write rate: at most one write every 2 cycles.
- Each write takes exactly one strobe, gated by audio_out_allowed sampled in the same cycle.
- busy is high in PLAY, GAP and DONE.
- The done pulse occurs the cycle after the final write.
- IDLE follows the done pulse; a new grant can be made in the next cycle.
- When several requests are pending, the lowest index is always granted next. Starvation of high indices is accepted.

## Configuration
- SFX_PREEMPT_EN defined:
  - In GAP only, if a pending index lower than grant_id exists, abort the current tone.
  - The aborted requester gets no done pulse and its pending bit stays cleared.
  - The lower index is then loaded exactly as in IDLE, and the FSM enters PLAY at the next edge.
- SFX_PREEMPT_EN undefined: tones always run to completion; non-preemptive.

## Structure
- Package sfx_pkg holds:
  - the state enum (IDLE, PLAY, GAP, DONE);
  - the HP_W and LEN_W defaults;
  - the AMPLITUDE default.
- Sub-module sfx_priority_pick: combinational find-first-set over NUM_REQ bits, outputting index and valid. It is shared by the IDLE grant and the preemption check.

## Test plan
- Single tone: req[2] with half_period=2, len=6, audio_out_allowed=1 constantly.
  - Expect 6 write strobes, 2 cycles apart, with samples +A,+A,-A,-A,+A,+A.
  - Expect done[2] one cycle after the last strobe; grant_id = 2.
- Simultaneous triggers: req = 4'b1010 in the same cycle, len=3 each.
  - Expect requester 1 served fully, then requester 3.
  - Expect done[1] before done[3]; total 6 strobes.
- Backpressure: audio_out_allowed low for 10 cycles mid-tone.
  - Expect no strobes while low; the sample sequence resumes unchanged.
- Edge values: len=0, and half_period=0.
  - len=0 gives done with no strobes.
  - half_period=0 behaves as 1: the sign alternates on every sample.
- Reset mid-tone: resetn low during PLAY.
  - Expect all outputs 0, no done pulse, pending cleared; the next req starts cleanly.
- Preemption, with SFX_PREEMPT_EN defined: req[3] with len=100, then req[0] after 5 writes.
  - Expect requester 0 granted at the next GAP and no done[3].
  - Undefined: requester 3 completes all 100 writes first.
